// File: rtl/capture_video_v2_pkg.sv
// Shared types and helpers for the v2 video capture block: FSM encoding,
// TKEEP lane helper and reset constants.
package capture_video_v2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_CAPTURE  = 2'd2,
        ST_DROP     = 2'd3
    } cap_state_t;

    localparam cap_state_t  STATE_RST  = ST_IDLE;
    localparam logic [15:0] FRAMES_RST = 16'd0;

    // A TKEEP byte lane is on when it falls inside the filled pixel slots.
    function automatic logic keep_lane_on(input int lane, input int pixels, input int bytes_per_pix);
        return lane < pixels * bytes_per_pix;
    endfunction

endpackage

// File: rtl/capture_video_v2_fifo.sv
// Synchronous show-ahead FIFO; the head word is visible on pop_data while not empty.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module capture_video_v2_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/capture_video_v2.sv
// Parallel video to AXI4-Stream capture: registers the pixel bus, packs
// PIX_PER_BEAT pixels per beat and queues beats in a FIFO toward the stream.
module capture_video_v2
    import capture_video_v2_pkg::*;
#(
    parameter int PIX_WIDTH    = 8,
    parameter int PIX_PER_BEAT = 4,
    parameter int FIFO_DEPTH   = 16,
    parameter int LINE_W_BITS  = 12
) (
    input  logic                                ACLK,
    input  logic                                ARESET,
    input  logic                                vid_valid,
    input  logic [PIX_WIDTH-1:0]                vid_data,
    input  logic                                vid_sof,
    input  logic                                vid_eol,
    input  logic                                cfg_enable,
    input  logic                                cfg_single,
    input  logic                                cfg_arm,
    input  logic                                cfg_clear,
    output logic                                status_busy,
    output logic                                status_overflow,
    output logic                                status_sync_err,
    output logic [15:0]                         status_frames,
    output logic [LINE_W_BITS-1:0]              status_line_len,
    output logic                                M_AXIS_TVALID,
    output logic [PIX_WIDTH*PIX_PER_BEAT-1:0]   M_AXIS_TDATA,
    output logic [PIX_WIDTH*PIX_PER_BEAT/8-1:0] M_AXIS_TKEEP,
    output logic                                M_AXIS_TUSER,
    output logic                                M_AXIS_TLAST,
    input  logic                                M_AXIS_TREADY
);

    localparam int BEAT_W = PIX_WIDTH * PIX_PER_BEAT;
    localparam int KEEP_W = BEAT_W / 8;
    localparam int BPP    = PIX_WIDTH / 8;
    localparam int SLOT_W = (PIX_PER_BEAT > 1) ? $clog2(PIX_PER_BEAT) : 1;
    localparam int FIFO_W = BEAT_W + KEEP_W + 2;
    localparam logic [LINE_W_BITS-1:0] LINE_MAX = '1;

    function automatic logic [LINE_W_BITS-1:0] sat_inc(input logic [LINE_W_BITS-1:0] v);
        return (v == LINE_MAX) ? v : v + 1'b1;
    endfunction

    cap_state_t             state;
    logic [SLOT_W-1:0]      slot;
    logic [BEAT_W-1:0]      beat_data;
    logic                   beat_user;
    logic [LINE_W_BITS-1:0] line_cnt;

    logic                   vld_p0;
    logic [PIX_WIDTH-1:0]   data_p0;
    logic                   sof_p0;
    logic                   eol_p0;

    logic                   sof_v;
    logic                   cap;
    logic                   emit;
    logic                   ovf_set;
    logic                   sync_set;
    logic                   push;
    logic                   pop;
    logic [SLOT_W-1:0]      eff_slot;
    logic [SLOT_W:0]        fill;
    logic [BEAT_W-1:0]      work;
    logic                   work_user;
    logic [KEEP_W-1:0]      work_keep;
    logic [LINE_W_BITS-1:0] line_inc;
    logic [FIFO_W-1:0]      fifo_word;
    logic                   fifo_full;
    logic                   fifo_empty;

    // Stage p0: register the free-running pixel bus
    always_ff @(posedge ACLK) begin
        if (ARESET) vld_p0 <= 1'b0;
        else        vld_p0 <= vid_valid;
    end

    always_ff @(posedge ACLK) begin
        data_p0 <= vid_data;
        sof_p0  <= vid_sof;
        eol_p0  <= vid_eol;
    end

    // Packer: merge the p0 pixel into the open beat and decide on emission
    always_comb begin
        sof_v     = vld_p0 && sof_p0;
        cap       = 1'b0;
        if (cfg_enable && vld_p0) begin
            case (state)
                ST_WAIT_SOF: cap = sof_p0;
                ST_CAPTURE:  cap = !(sof_p0 && cfg_single);
                ST_DROP:     cap = sof_p0 && !cfg_single;
                default:     cap = 1'b0;
            endcase
        end
        sync_set  = cfg_enable && (state == ST_CAPTURE) && sof_v && (slot != '0);
        eff_slot  = sof_p0 ? '0 : slot;
        fill      = {1'b0, eff_slot} + 1'b1;
        work      = (eff_slot == '0) ? '0 : beat_data;
        for (int i = 0; i < PIX_PER_BEAT; i++) begin
            if (eff_slot == SLOT_W'(i)) work[i*PIX_WIDTH +: PIX_WIDTH] = data_p0;
        end
        work_user = (eff_slot == '0) ? sof_p0 : beat_user;
        for (int i = 0; i < KEEP_W; i++) begin
            work_keep[i] = keep_lane_on(i, int'(fill), BPP);
        end
        emit      = cap && (eol_p0 || (eff_slot == SLOT_W'(PIX_PER_BEAT-1)));
        ovf_set   = emit && fifo_full && !pop;
        push      = emit && !ovf_set;
        line_inc  = sat_inc(sof_p0 ? '0 : line_cnt);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state           <= STATE_RST;
            status_busy     <= 1'b0;
            slot            <= '0;
            line_cnt        <= '0;
            status_line_len <= '0;
            status_frames   <= FRAMES_RST;
            status_overflow <= 1'b0;
            status_sync_err <= 1'b0;
        end else begin
            if (!cfg_enable) begin
                state       <= ST_IDLE;
                status_busy <= 1'b0;
            end else if (ovf_set) begin
                state       <= ST_DROP;
                status_busy <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: if (!cfg_single || cfg_arm) begin
                        state       <= ST_WAIT_SOF;
                        status_busy <= 1'b1;
                    end
                    ST_WAIT_SOF: if (sof_v) begin
                        state       <= ST_CAPTURE;
                        status_busy <= 1'b1;
                    end
                    ST_CAPTURE: if (sof_v && cfg_single) begin
                        state       <= ST_IDLE;
                        status_busy <= 1'b0;
                    end
                    ST_DROP: if (sof_v) begin
                        state       <= cfg_single ? ST_IDLE : ST_CAPTURE;
                        status_busy <= !cfg_single;
                    end
                    default: begin
                        state       <= ST_IDLE;
                        status_busy <= 1'b0;
                    end
                endcase
            end

            // A rejected SOF or a disable abandons whatever partial beat was open
            if (cap)                        slot <= emit ? '0 : fill[SLOT_W-1:0];
            else if (!cfg_enable || sof_v)  slot <= '0;

            if (cap && sof_p0) status_frames <= status_frames + 16'd1;

            if (cap) begin
                if (eol_p0) begin
                    status_line_len <= line_inc;
                    line_cnt        <= '0;
                end else begin
                    line_cnt <= line_inc;
                end
            end

            if (ovf_set)        status_overflow <= 1'b1;
            else if (cfg_clear) status_overflow <= 1'b0;
            if (sync_set)       status_sync_err <= 1'b1;
            else if (cfg_clear) status_sync_err <= 1'b0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (cap) begin
            beat_data <= work;
            beat_user <= work_user;
        end
    end

    // Stage p1: completed beats queued toward the stream
    capture_video_v2_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (ACLK),
        .rst       (ARESET),
        .push      (push),
        .push_data ({work_user, eol_p0, work_keep, work}),
        .pop       (pop),
        .pop_data  (fifo_word),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign M_AXIS_TVALID = !fifo_empty;
    assign pop           = M_AXIS_TVALID && M_AXIS_TREADY;
    assign M_AXIS_TDATA  = fifo_empty ? '0   : fifo_word[BEAT_W-1:0];
    assign M_AXIS_TKEEP  = fifo_empty ? '0   : fifo_word[BEAT_W +: KEEP_W];
    assign M_AXIS_TLAST  = fifo_empty ? 1'b0 : fifo_word[BEAT_W+KEEP_W];
    assign M_AXIS_TUSER  = fifo_empty ? 1'b0 : fifo_word[BEAT_W+KEEP_W+1];

endmodule

// File: tb/tb_capture_video_v2.sv
// Directed and randomized bench for capture_video_v2 with a pixel-list
// reference model that predicts stream beats, frame count and line length.
module tb_capture_video_v2;

    localparam int PW  = 8;
    localparam int PPB = 4;
    localparam int FD  = 4;
    localparam int LW  = 12;
    localparam int BW  = PW * PPB;
    localparam int KW  = BW / 8;

    typedef logic [BW+KW+1:0] beat_t;   // {user, last, keep, data}

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic          vid_valid, vid_sof, vid_eol;
    logic [PW-1:0] vid_data;
    logic          cfg_enable, cfg_single, cfg_arm, cfg_clear;
    logic          status_busy, status_overflow, status_sync_err;
    logic [15:0]   status_frames;
    logic [LW-1:0] status_line_len;
    logic          M_AXIS_TVALID, M_AXIS_TUSER, M_AXIS_TLAST, M_AXIS_TREADY;
    logic [BW-1:0] M_AXIS_TDATA;
    logic [KW-1:0] M_AXIS_TKEEP;

    capture_video_v2 #(
        .PIX_WIDTH(PW), .PIX_PER_BEAT(PPB), .FIFO_DEPTH(FD), .LINE_W_BITS(LW)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .vid_valid(vid_valid), .vid_data(vid_data), .vid_sof(vid_sof), .vid_eol(vid_eol),
        .cfg_enable(cfg_enable), .cfg_single(cfg_single), .cfg_arm(cfg_arm), .cfg_clear(cfg_clear),
        .status_busy(status_busy), .status_overflow(status_overflow),
        .status_sync_err(status_sync_err), .status_frames(status_frames),
        .status_line_len(status_line_len),
        .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TKEEP(M_AXIS_TKEEP),
        .M_AXIS_TUSER(M_AXIS_TUSER), .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TREADY(M_AXIS_TREADY)
    );

    always #5 ACLK = ~ACLK;

    int    vectors = 0;
    int    miscompares = 0;
    beat_t got_q[$];
    beat_t exp_q[$];

    // reference model state
    bit            m_started;
    logic [PW-1:0] cur[$];
    bit            cur_user;
    int            m_frames;
    int            m_line;
    logic [LW-1:0] m_line_len;
    bit            m_sync;

    always @(negedge ACLK) begin
        if (M_AXIS_TVALID && M_AXIS_TREADY)
            got_q.push_back({M_AXIS_TUSER, M_AXIS_TLAST, M_AXIS_TKEEP, M_AXIS_TDATA});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic model_reset();
        m_started = 0; cur.delete(); cur_user = 0;
        m_frames = 0; m_line = 0; m_line_len = '0; m_sync = 0;
    endtask

    task automatic model_pix(input logic [PW-1:0] d, input bit sof, input bit eol);
        beat_t b;
        if (!m_started && !sof) return;
        m_started = 1;
        if (sof) begin
            if (cur.size() != 0) m_sync = 1;
            cur.delete();
            m_frames++;
            m_line = 0;
        end
        if (cur.size() == 0) cur_user = sof;
        cur.push_back(d);
        if (m_line < (1 << LW) - 1) m_line++;
        if (eol) begin
            m_line_len = LW'(m_line);
            m_line = 0;
        end
        if (cur.size() == PPB || eol) begin
            b = '0;
            for (int i = 0; i < cur.size(); i++) begin
                b[i*PW +: PW] = cur[i];
                b[BW + i] = 1'b1;
            end
            b[BW+KW]   = eol;
            b[BW+KW+1] = cur_user;
            exp_q.push_back(b);
            cur.delete();
        end
    endtask

    task automatic pix(input logic [PW-1:0] d, input bit sof, input bit eol, input bit modeled);
        vid_valid = 1'b1; vid_data = d; vid_sof = sof; vid_eol = eol;
        if (modeled) model_pix(d, sof, eol);
        step();
        vid_valid = 1'b0; vid_sof = 1'b0; vid_eol = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        M_AXIS_TREADY = 1'b1;
        repeat (3) step();
        n = 0;
        while (M_AXIS_TVALID && n < 100) begin
            step();
            n++;
        end
        check({tag, "_drain_bound"}, 64'(n < 100), 64'(1));
        step();
    endtask

    task automatic compare_beats(input string tag);
        int n;
        check({tag, "_beat_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_beat%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        beat_t b;
        int    nl, len;
        bit    s;
        ARESET = 1'b1; vid_valid = 1'b0; vid_data = '0; vid_sof = 1'b0; vid_eol = 1'b0;
        cfg_enable = 1'b0; cfg_single = 1'b0; cfg_arm = 1'b0; cfg_clear = 1'b0;
        M_AXIS_TREADY = 1'b1;
        model_reset();
        repeat (3) step();

        check("rst_tvalid", 64'(M_AXIS_TVALID), 64'(0));
        check("rst_tdata",  64'(M_AXIS_TDATA),  64'(0));
        check("rst_tkeep",  64'(M_AXIS_TKEEP),  64'(0));
        check("rst_tuser",  64'(M_AXIS_TUSER),  64'(0));
        check("rst_tlast",  64'(M_AXIS_TLAST),  64'(0));
        check("rst_busy",   64'(status_busy),   64'(0));
        check("rst_ovf",    64'(status_overflow), 64'(0));
        check("rst_sync",   64'(status_sync_err), 64'(0));
        check("rst_frames", 64'(status_frames), 64'(0));
        check("rst_linelen", 64'(status_line_len), 64'(0));

        ARESET = 1'b0;
        cfg_enable = 1'b1;
        repeat (3) step();
        check("enable_busy", 64'(status_busy), 64'(1));

        // two lines of eight pixels, values 0x01..0x10
        for (int l = 0; l < 2; l++)
            for (int p = 0; p < 8; p++)
                pix(PW'(l*8 + p + 1), (l == 0 && p == 0), (p == 7), 1'b1);
        drain("frame8");
        check("frame8_nbeats", 64'(got_q.size()), 64'(4));
        if (got_q.size() >= 4) begin
            b = got_q[0];
            check("frame8_b0_data", 64'(b[BW-1:0]), 64'(32'h04030201));
            check("frame8_b0_user", 64'(b[BW+KW+1]), 64'(1));
            b = got_q[1];
            check("frame8_b1_last", 64'(b[BW+KW]), 64'(1));
            b = got_q[3];
            check("frame8_b3_last", 64'(b[BW+KW]), 64'(1));
            check("frame8_b3_data", 64'(b[BW-1:0]), 64'(32'h100f0e0d));
        end
        check("frame8_frames", 64'(status_frames), 64'(1));
        check("frame8_linelen", 64'(status_line_len), 64'(8));
        compare_beats("frame8");

        // six-pixel line leaves a two-pixel last beat
        for (int p = 0; p < 6; p++) pix(PW'(8'h21 + p), (p == 0), (p == 5), 1'b1);
        drain("line6");
        if (got_q.size() >= 2) begin
            b = got_q[1];
            check("line6_b1_keep", 64'(b[BW +: KW]), 64'(4'h3));
            check("line6_b1_last", 64'(b[BW+KW]), 64'(1));
            check("line6_b1_data", 64'(b[BW-1:0]), 64'(32'h00002625));
        end
        check("line6_linelen", 64'(status_line_len), 64'(6));
        compare_beats("line6");

        // randomized frames, lines of 1..11 pixels, occasional early SOF and idle gaps
        for (int f = 0; f < 8; f++) begin
            nl = $urandom_range(1, 3);
            for (int l = 0; l < nl; l++) begin
                len = $urandom_range(1, 11);
                for (int p = 0; p < len; p++) begin
                    s = (l == 0 && p == 0) || ($urandom_range(0, 19) == 0);
                    pix(PW'($urandom), s, (p == len - 1), 1'b1);
                    if ($urandom_range(0, 3) == 0) step();
                end
            end
        end
        drain("rand");
        compare_beats("rand");
        check("rand_frames",  64'(status_frames), 64'(m_frames[15:0]));
        check("rand_linelen", 64'(status_line_len), 64'(m_line_len));
        check("rand_sync",    64'(status_sync_err), 64'(m_sync));

        // SOF after two pixels of a line
        cfg_clear = 1'b1; step(); cfg_clear = 1'b0; m_sync = 0; step();
        check("sync_cleared0", 64'(status_sync_err), 64'(0));
        pix(8'h31, 1'b1, 1'b0, 1'b1);
        pix(8'h32, 1'b0, 1'b0, 1'b1);
        for (int p = 0; p < 4; p++) pix(PW'(8'h41 + p), (p == 0), (p == 3), 1'b1);
        drain("sync");
        check("sync_flag", 64'(status_sync_err), 64'(1));
        check("sync_nbeats", 64'(got_q.size()), 64'(1));
        if (got_q.size() >= 1) begin
            b = got_q[0];
            check("sync_b0_data", 64'(b[BW-1:0]), 64'(32'h44434241));
            check("sync_b0_user", 64'(b[BW+KW+1]), 64'(1));
        end
        compare_beats("sync");
        cfg_clear = 1'b1; step(); cfg_clear = 1'b0; m_sync = 0; step();
        check("sync_cleared", 64'(status_sync_err), 64'(0));

        // back-pressure overflow with a four-deep FIFO
        M_AXIS_TREADY = 1'b0;
        for (int i = 0; i < 24; i++) pix(PW'(8'h50 + i), (i == 0), 1'b0, (i < 16));
        m_started = 0;
        cur.delete();
        repeat (2) step();
        check("ovf_flag", 64'(status_overflow), 64'(1));
        check("ovf_busy", 64'(status_busy), 64'(1));
        check("ovf_tvalid", 64'(M_AXIS_TVALID), 64'(1));
        check("ovf_head_stable", 64'(M_AXIS_TDATA), 64'(32'h53525150));
        drain("ovf");
        check("ovf_nbeats", 64'(got_q.size()), 64'(4));
        compare_beats("ovf");
        for (int p = 0; p < 4; p++) pix(PW'(8'h70 + p), (p == 0), (p == 3), 1'b1);
        drain("resume");
        compare_beats("resume");
        check("resume_frames", 64'(status_frames), 64'(m_frames[15:0]));
        check("ovf_sticky", 64'(status_overflow), 64'(1));
        cfg_clear = 1'b1; step(); cfg_clear = 1'b0; step();
        check("ovf_cleared", 64'(status_overflow), 64'(0));

        // single-shot after a fresh reset
        ARESET = 1'b1; step(); ARESET = 1'b0;
        model_reset();
        cfg_enable = 1'b0; cfg_single = 1'b1; step();
        cfg_enable = 1'b1; repeat (3) step();
        check("single_idle_busy", 64'(status_busy), 64'(0));
        cfg_arm = 1'b1; step(); cfg_arm = 1'b0; step();
        check("single_armed_busy", 64'(status_busy), 64'(1));
        for (int f = 0; f < 3; f++) begin
            for (int p = 0; p < 4; p++) pix(PW'(8'h90 + f*16 + p), (p == 0), (p == 3), (f == 0));
            repeat (2) step();
        end
        drain("single");
        compare_beats("single");
        check("single_busy_end", 64'(status_busy), 64'(0));
        check("single_frames", 64'(status_frames), 64'(1));

        // reset in the middle of a line with a beat queued
        cfg_single = 1'b0;
        repeat (3) step();
        M_AXIS_TREADY = 1'b0;
        for (int p = 0; p < 5; p++) pix(PW'(8'hA0 + p), (p == 0), 1'b0, 1'b0);
        repeat (2) step();
        check("midrst_pre_tvalid", 64'(M_AXIS_TVALID), 64'(1));
        ARESET = 1'b1;
        step();
        check("midrst_tvalid", 64'(M_AXIS_TVALID), 64'(0));
        check("midrst_busy",   64'(status_busy), 64'(0));
        check("midrst_ovf",    64'(status_overflow), 64'(0));
        check("midrst_sync",   64'(status_sync_err), 64'(0));
        check("midrst_frames", 64'(status_frames), 64'(0));
        check("midrst_linelen", 64'(status_line_len), 64'(0));
        ARESET = 1'b0;
        M_AXIS_TREADY = 1'b1;
        repeat (3) step();
        check("midrst_no_beats", 64'(got_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
